// File: rtl/alu_issue_scheduler_pkg.sv
// Shared lane definitions: datapath types, ALU opcodes and the ALU pipeline depth
// that the issue scheduler's tag pipeline is aligned to.
package alu_issue_scheduler_pkg;

  localparam int DATA_W      = 32;
  localparam int PC_W        = 16;
  localparam int ALU_LATENCY = 2;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic [PC_W-1:0]          instruction_memory_address_t;

  typedef enum logic [3:0] {
    NOP  = 4'd0,
    ADD  = 4'd1,
    SUB  = 4'd2,
    ADDI = 4'd3,
    MULI = 4'd4
  } alu_instruction_t;

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// Request, ALU-drive and response bundle between the lane requesters, the shared
// ALU and the issue scheduler.
interface alu_issue_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  import alu_issue_scheduler_pkg::*;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  alu_instruction_t            req_instr [NUM_REQ];
  data_t                       req_op1   [NUM_REQ];
  data_t                       req_op2   [NUM_REQ];
  data_t                       req_imm   [NUM_REQ];
  instruction_memory_address_t req_pc    [NUM_REQ];

  logic                        alu_enable;
  alu_instruction_t            alu_instr;
  data_t                       alu_op1;
  data_t                       alu_op2;
  data_t                       alu_imm;
  instruction_memory_address_t alu_pc;
  data_t                       alu_result;

  logic                        resp_valid;
  logic                        resp_ready;
  logic [ID_W-1:0]             resp_id;
  data_t                       resp_data;
  logic [31:0]                 issue_count;

  // Scheduler side
  modport slave (
    input  req_valid, req_instr, req_op1, req_op2, req_imm, req_pc,
    input  alu_result, resp_ready,
    output req_ready, alu_enable, alu_instr, alu_op1, alu_op2, alu_imm, alu_pc,
    output resp_valid, resp_id, resp_data, issue_count
  );

  // Requesters, ALU and response consumer side
  modport master (
    output req_valid, req_instr, req_op1, req_op2, req_imm, req_pc,
    output alu_result, resp_ready,
    input  req_ready, alu_enable, alu_instr, alu_op1, alu_op2, alu_imm, alu_pc,
    input  resp_valid, resp_id, resp_data, issue_count
  );

endinterface

// File: rtl/alu_issue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request scanning upward
// from ptr, wrapping modulo NUM_REQ.
module alu_issue_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  int idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue of NUM_REQ requesters onto one shared 2-stage ALU, with a tag
// pipeline that returns each result to its owner; a stalled consumer freezes everything.
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_scheduler_if.slave  bus
);

  logic               stall;
  logic               can_issue;
  logic               hs;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               any;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    ptr_next;

  logic               vld_p1;
  logic               vld_p2;
  logic [ID_W-1:0]    id_p1;
  logic [ID_W-1:0]    id_p2;
  logic [31:0]        issue_count_q;

  alu_issue_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (bus.req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any)
  );

  // resp_ready only reaches issue through stall; resp_valid is purely registered
  assign stall          = vld_p2 & ~bus.resp_ready;
  assign can_issue      = ~stall & rst_n;
  assign hs             = any & can_issue;
  assign bus.alu_enable = ~stall;
  assign bus.req_ready  = grant & {NUM_REQ{can_issue}};

  assign ptr_next = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);

  // p0: winner operand mux onto the ALU ports
  always_comb begin
    bus.alu_instr = NOP;
    bus.alu_op1   = '0;
    bus.alu_op2   = '0;
    bus.alu_imm   = '0;
    bus.alu_pc    = '0;
    if (hs) begin
      bus.alu_instr = bus.req_instr[grant_id];
      bus.alu_op1   = bus.req_op1[grant_id];
      bus.alu_op2   = bus.req_op2[grant_id];
      bus.alu_imm   = bus.req_imm[grant_id];
      bus.alu_pc    = bus.req_pc[grant_id];
    end
  end

  // p1/p2: tag stages tracking the ALU register stages, plus issue bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      id_p1         <= '0;
      id_p2         <= '0;
      rr_ptr        <= '0;
      issue_count_q <= '0;
    end else if (!stall) begin
      vld_p1 <= hs;
      id_p1  <= grant_id;
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
      if (hs) begin
        rr_ptr        <= ptr_next;
        issue_count_q <= issue_count_q + 32'd1;
      end
    end
  end

  assign bus.resp_valid  = vld_p2;
  assign bus.resp_id     = id_p2;
  assign bus.resp_data   = bus.alu_result;
  assign bus.issue_count = issue_count_q;

endmodule
